// File: rtl/dv_sequencer.sv
// Test sequencer: waits for the DUT, runs NPHASE stimulus phases with a one-cycle
// gap between them, drains, waits for the checker, then reports pass or fail.
module dv_sequencer #(
  parameter int NPHASE  = 2,
  parameter int PW      = 4,
  parameter int DRAIN   = 16,
  parameter int TIMEOUT = 5000,
  parameter int CW      = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          dut_active,
  input  logic          cmds_done,
  input  logic          test_done,
  output logic          stim_go,
  output logic [PW-1:0] phase,
  output logic          draining,
  output logic          finish,
  output logic          pass,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic [2:0]    state_dbg
);

  // Handshake: every input is a level sampled on the rising edge; every output
  // is a flop, so a sampled input shows up on the outputs one edge later.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ACT  = 3'd1,
    S_RUN       = 3'd2,
    S_GAP       = 3'd3,
    S_DRAIN     = 3'd4,
    S_WAIT_TEST = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_t         state;
  state_t         state_nx;
  logic [DCW-1:0] drain_cnt;
  logic           active;
  logic           active_nx;
  logic           terminal;
  logic           terminal_nx;
  logic           wd_hit;

  assign state_dbg = state;

  always_comb begin
    active      = (state inside {S_WAIT_ACT, S_RUN, S_GAP, S_DRAIN, S_WAIT_TEST});
    terminal    = (state inside {S_DONE, S_FAIL});
    wd_hit      = active && (cycles == CW'(TIMEOUT - 1));
    state_nx    = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_WAIT_ACT;
      S_WAIT_ACT:  if (dut_active) state_nx = S_RUN;
      S_RUN: begin
        if (!dut_active)    state_nx = S_FAIL;
        else if (cmds_done) state_nx = (phase == PW'(NPHASE - 1)) ? S_DRAIN : S_GAP;
      end
      S_GAP:       state_nx = dut_active ? S_RUN : S_FAIL;
      S_DRAIN: begin
        if (!dut_active)                       state_nx = S_FAIL;
        else if (drain_cnt == DCW'(DRAIN - 1)) state_nx = S_WAIT_TEST;
      end
      S_WAIT_TEST: begin
        if (!dut_active)    state_nx = S_FAIL;
        else if (test_done) state_nx = S_DONE;
      end
      default:     state_nx = state;
    endcase
    // Watchdog outranks everything, including a coincident normal transition.
    if (wd_hit) state_nx = S_FAIL;
    active_nx   = (state_nx inside {S_WAIT_ACT, S_RUN, S_GAP, S_DRAIN, S_WAIT_TEST});
    terminal_nx = (state_nx inside {S_DONE, S_FAIL});
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= S_IDLE;
      stim_go   <= 1'b0;
      phase     <= '0;
      draining  <= 1'b0;
      finish    <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
      drain_cnt <= '0;
    end else begin
      state    <= state_nx;
      stim_go  <= (state_nx == S_RUN);
      draining <= (state_nx == S_DRAIN);
      finish   <= terminal_nx && !terminal;
      if (state_nx == S_DONE) pass <= 1'b1;
      if (wd_hit) timeout <= 1'b1;
      // The edge into DONE/FAIL does not count, so the frozen value is the last active one.
      if (state == S_IDLE)
        cycles <= '0;
      else if (active && active_nx && (cycles != '1))
        cycles <= cycles + CW'(1);
      if (state == S_WAIT_ACT && state_nx == S_RUN)
        phase <= '0;
      else if (state == S_GAP && state_nx == S_RUN)
        phase <= phase + PW'(1);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_dv_sequencer.sv
// Self-checking bench for dv_sequencer: directed scenarios with a result
// scoreboard popped on every finish pulse.
module tb_dv_sequencer;

  localparam int NPHASE  = 2;
  localparam int PW      = 4;
  localparam int DRAIN   = 4;
  localparam int TIMEOUT = 100;
  localparam int CW      = 32;
  localparam int RW      = 2 + PW + CW;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic          dut_active = 1'b0;
  logic          cmds_done = 1'b0;
  logic          test_done = 1'b0;
  logic          stim_go;
  logic [PW-1:0] phase;
  logic          draining;
  logic          finish;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fin    = 0;
  int n_drain  = 0;

  logic [RW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  dv_sequencer #(
    .NPHASE(NPHASE), .PW(PW), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .dut_active(dut_active),
    .cmds_done(cmds_done), .test_done(test_done), .stim_go(stim_go),
    .phase(phase), .draining(draining), .finish(finish), .pass(pass),
    .timeout(timeout), .cycles(cycles), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // scoreboard: one expected {pass, timeout, phase, cycles} per finish pulse
  always @(negedge clk) begin
    if (!nreset) begin
      n_fin   = 0;
      n_drain = 0;
    end else begin
      if (draining) n_drain++;
      if (finish) begin
        n_fin++;
        if (exp_q.size() == 0) check("finish_unexpected", 1, 0);
        else check("result", {pass, timeout, phase, cycles}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; start = 1'b0; dut_active = 1'b0; cmds_done = 1'b0; test_done = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stim_go"}, stim_go, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_draining"}, draining, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cycles"}, cycles, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic wait_stim(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = stim_go;
    end
    check(tag, seen, 1);
  endtask

  // Two phases of 6 RUN cycles, 1 GAP, 4 DRAIN, 4 WAIT_TEST, 1 WAIT_ACT:
  // 22 active cycles, so the frozen count is 21.
  task automatic run_normal(input string tag);
    bit gone = 1'b0;
    exp_q.push_back({1'b1, 1'b0, PW'(1), CW'(21)});
    dut_active = 1'b1;
    start = 1'b1;
    wait_stim({tag, "_stim0"});
    check({tag, "_phase0"}, phase, 0);
    repeat (5) @(negedge clk);
    cmds_done = 1'b1;
    @(negedge clk);
    check({tag, "_gap_stim"}, stim_go, 0);
    check({tag, "_gap_phase"}, phase, 0);
    cmds_done = 1'b0;
    @(negedge clk);
    check({tag, "_run1_stim"}, stim_go, 1);
    check({tag, "_run1_phase"}, phase, 1);
    repeat (5) @(negedge clk);
    cmds_done = 1'b1;
    @(negedge clk);
    check({tag, "_drain_on"}, draining, 1);
    check({tag, "_drain_stim"}, stim_go, 0);
    cmds_done = 1'b0;
    for (int k = 0; k < 20 && !gone; k++) begin
      @(negedge clk);
      gone = !draining;
    end
    check({tag, "_drain_end"}, gone, 1);
    repeat (3) @(negedge clk);
    test_done = 1'b1;
    @(negedge clk);
    check({tag, "_pass"}, pass, 1);
    check({tag, "_finish"}, finish, 1);
    test_done = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_finish_drop"}, finish, 0);
    start = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_pass_hold"}, pass, 1);
    check({tag, "_cycles_frozen"}, cycles, 21);
    check({tag, "_n_finish"}, n_fin, 1);
    check({tag, "_n_drain"}, n_drain, DRAIN);
    start = 1'b0;
  endtask

  initial begin
    bit seen;
    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    nreset = 1'b1;

    // normal pass
    run_normal("norm");

    // watchdog: test_done never arrives
    do_reset();
    exp_q.push_back({1'b0, 1'b1, PW'(1), CW'(TIMEOUT - 1)});
    dut_active = 1'b1; start = 1'b1; cmds_done = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 * TIMEOUT && !seen; k++) begin
      @(negedge clk);
      seen = finish;
    end
    check("wd_finish_seen", seen, 1);
    check("wd_timeout", timeout, 1);
    check("wd_pass", pass, 0);
    cmds_done = 1'b0;
    repeat (3) @(negedge clk);
    check("wd_n_finish", n_fin, 1);
    check("wd_stim_go", stim_go, 0);

    // DUT drops during phase 1
    do_reset();
    exp_q.push_back({1'b0, 1'b0, PW'(1), CW'(3)});
    dut_active = 1'b1; start = 1'b1;
    wait_stim("drop_stim0");
    cmds_done = 1'b1;
    @(negedge clk);
    cmds_done = 1'b0;
    @(negedge clk);
    check("drop_run1_phase", phase, 1);
    check("drop_run1_stim", stim_go, 1);
    dut_active = 1'b0;
    @(negedge clk);
    check("drop_stim_off", stim_go, 0);
    check("drop_timeout", timeout, 0);
    check("drop_finish", finish, 1);
    repeat (3) @(negedge clk);
    check("drop_phase_frozen", phase, 1);
    check("drop_cycles_frozen", cycles, 3);

    // last cmds_done coincides with the watchdog
    do_reset();
    exp_q.push_back({1'b0, 1'b1, PW'(1), CW'(TIMEOUT - 1)});
    dut_active = 1'b1; start = 1'b1;
    wait_stim("coll_stim0");
    cmds_done = 1'b1;
    @(negedge clk);
    cmds_done = 1'b0;
    @(negedge clk);
    check("coll_phase1", phase, 1);
    repeat (TIMEOUT - 4) @(negedge clk);
    cmds_done = 1'b1;
    @(negedge clk);
    check("coll_timeout", timeout, 1);
    check("coll_finish", finish, 1);
    check("coll_draining", draining, 0);
    cmds_done = 1'b0;
    repeat (6) @(negedge clk);
    check("coll_n_drain", n_drain, 0);
    check("coll_pass", pass, 0);

    // reset in the middle of DRAIN, then a clean rerun
    do_reset();
    dut_active = 1'b1; start = 1'b1; cmds_done = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = draining;
    end
    check("mid_drain_seen", seen, 1);
    nreset = 1'b0; start = 1'b0; cmds_done = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    run_normal("rerun");

    // late DUT: start high, dut_active held low
    do_reset();
    start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen |= stim_go;
    end
    check("late_no_stim", seen, 0);
    dut_active = 1'b1;
    @(negedge clk);
    check("late_stim", stim_go, 1);
    check("late_phase", phase, 0);

    // final report
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dv_sequencer.md
# dv_sequencer

Synthesizable test sequencer for the simulation harness. It sits between the harness control block, which supplies `start`, and the stimulus generators and DUT. It waits for the DUT to report active, runs a fixed number of stimulus phases back-to-back, drains, waits for the checker's `test_done`, and then reports pass or fail. A cycle watchdog guarantees the test ends.

## Interface
- `NPHASE`, 2: number of stimulus phases run in order; must be ≥1.
- `PW`, 4: width of `phase`; must satisfy 2^PW ≥ NPHASE.
- `DRAIN`, 16: idle cycles between the last phase's `cmds_done` and the start of waiting for `test_done`; must be ≥1.
- `TIMEOUT`, 5000: watchdog limit in cycles, counted from leaving IDLE.
- `CW`, 32: width of `cycles`; must satisfy 2^CW > TIMEOUT.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `nreset` in 1: synchronous, active-low reset.
- `start` in 1: level input from the harness; only sampled in IDLE.
- `dut_active` in 1: DUT has left its reset sequence.
- `cmds_done` in 1: current phase's stimulus has finished (level).
- `test_done` in 1: checker reports test complete (level).
- `stim_go` out 1: enables the stimulus generator for the current phase.
- `phase` out PW: index of the current phase.
- `draining` out 1: high while in DRAIN.
- `finish` out 1: one-cycle pulse on entry to DONE or FAIL.
- `pass` out 1: sticky; test passed.
- `timeout` out 1: sticky; watchdog expired.
- `cycles` out CW: elapsed-cycle counter.

## Operation
- FSM states: IDLE, WAIT_ACT, RUN, GAP, DRAIN, WAIT_TEST, DONE, FAIL.
- **IDLE:** `start`=1 → WAIT_ACT. `cycles` clears to 0.
- **WAIT_ACT:** `dut_active`=1 → RUN with `phase`=0.
- **RUN:** `stim_go`=1. When `cmds_done`=1:
  - `phase`==NPHASE-1 → DRAIN.
  - otherwise → GAP.
- **GAP:** exactly one cycle with `stim_go`=0, so the generator sees a falling edge; `phase` increments on exit → RUN.
- **DRAIN:** an internal counter counts DRAIN cycles, then → WAIT_TEST.
- **WAIT_TEST:** `test_done`=1 → DONE.
- **DONE:** `pass`=1. DONE and FAIL are terminal; only `nreset` leaves them. `start` is ignored there.
- **Active states:** WAIT_ACT, RUN, GAP, DRAIN and WAIT_TEST. In these, `cycles` increments by 1 each cycle and saturates at all-ones.
- **Watchdog:** in an active state with `cycles`==TIMEOUT-1 → FAIL and `timeout`=1.
- **Loss of `dut_active`:** `dut_active`=0 in RUN, GAP, DRAIN or WAIT_TEST → FAIL with `timeout`=0.
- **Priority when events coincide:** watchdog > `dut_active` loss > normal transition. Example: `cmds_done` and timeout in the same cycle → FAIL.
- In DONE/FAIL, `cycles` and `phase` freeze at their last values.
- `cmds_done` already high on entry to RUN completes that phase on the first RUN cycle. The generator is expected to drop it during GAP.

## Timing
- All outputs are registered and decoded from the state.
- Reset values: `stim_go`=0, `phase`=0, `draining`=0, `finish`=0, `pass`=0, `timeout`=0, `cycles`=0, state=IDLE.
- Reset mid-test returns to IDLE on the next edge and drops `stim_go` immediately at that edge.
- Single-phase handshake timeline:
  - `start` sampled at edge N → WAIT_ACT at N+1.
  - `dut_active` sampled high at edge N+1 → `stim_go`=1 from N+2.
  - `cmds_done` sampled at edge M → `stim_go`=0 from M+1.
- Phase-to-phase latency: `cmds_done` at edge M → GAP during M+1 → `stim_go`=1 and `phase`+1 from M+2.
- `draining` is high for exactly DRAIN cycles.
- `test_done` sampled at edge T → `pass`=1 and `finish`=1 from T+1; `finish` returns to 0 at T+2.
- `finish` fires exactly once per reset.

## Test plan
- **Normal pass:** NPHASE=2, DRAIN=4, TIMEOUT=100; `dut_active` and `start` high, each `cmds_done` asserted 5 cycles after `stim_go` rises, `test_done` at the end → `phase` goes 0 then 1, one GAP cycle with `stim_go`=0, `draining` high 4 cycles, `pass`=1, single `finish` pulse, `cycles`=21 at freeze.
- **Watchdog:** TIMEOUT=100 and `test_done` never asserted → FAIL with `timeout`=1, `pass`=0, `cycles`=99, one `finish` pulse.
- **DUT drop:** `dut_active` driven low during phase 1 RUN → FAIL next edge, `stim_go`=0, `timeout`=0, `phase`=1 frozen.
- **Collision:** `cmds_done` of the last phase arrives in the same cycle `cycles`==TIMEOUT-1 → FAIL with `timeout`=1; DRAIN is never entered.
- **Reset mid-operation:** `nreset` low for 1 cycle during DRAIN → all outputs return to reset values; a rerun with `start` passes normally.
- **Late DUT:** `start` high but `dut_active` held low for 10 cycles → `stim_go` stays 0; `stim_go`=1 one cycle after `dut_active` is sampled high.
